// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one binary stage (16, 8, 4, 2, 1) per clock,
// so every shift takes exactly five SHIFT cycles regardless of shamt.
module shift_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [2:0]  counter;
    logic [31:0] work;
    logic [4:0]  amt;
    logic        op_r;
    logic [31:0] shifted;
    logic        stage_sel;
    logic [31:0] work_next;
    logic        accept;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign work_next = stage_sel ? shifted : work;

    // op_r = 1 replicates bit 31 into the vacated upper bits; op_r = 0 zero-fills from the bottom.
    always_comb begin
        shifted   = work;
        stage_sel = 1'b0;
        case (counter)
            3'd4: begin
                stage_sel = amt[4];
                shifted   = op_r ? {{16{work[31]}}, work[31:16]} : {work[15:0], 16'b0};
            end
            3'd3: begin
                stage_sel = amt[3];
                shifted   = op_r ? {{8{work[31]}}, work[31:8]} : {work[23:0], 8'b0};
            end
            3'd2: begin
                stage_sel = amt[2];
                shifted   = op_r ? {{4{work[31]}}, work[31:4]} : {work[27:0], 4'b0};
            end
            3'd1: begin
                stage_sel = amt[1];
                shifted   = op_r ? {{2{work[31]}}, work[31:2]} : {work[29:0], 2'b0};
            end
            3'd0: begin
                stage_sel = amt[0];
                shifted   = op_r ? {work[31], work[31:1]} : {work[30:0], 1'b0};
            end
            default: begin
                stage_sel = 1'b0;
                shifted   = work;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= 3'd0;
            work     <= 32'h0000_0000;
            amt      <= 5'd0;
            op_r     <= 1'b0;
            data_out <= 32'h0000_0000;
        end else if (accept) begin
            work    <= data_in;
            amt     <= shamt;
            op_r    <= op;
            counter <= 3'd4;
            state   <= SHIFT;
        end else if (state == SHIFT) begin
            work <= work_next;
            // Counter stops at zero; the stage-0 edge publishes the result.
            if (counter == 3'd0) begin
                data_out <= work_next;
                state    <= DONE;
            end else begin
                counter <= counter - 3'd1;
            end
        end else begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed-vector bench for shift_sequencer: latency, shift results,
// ignored starts, back-to-back issue and asynchronous reset.
module tb_shift_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int compared;
    int mismatched;

    shift_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt    (shamt),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issues one operation and observes it for eight edges after acceptance; inputs are scrambled after the accepting edge.
    task automatic run_op(input logic op_v, input logic [31:0] data_v, input logic [4:0] shamt_v,
                          output int busy_cycles, output int latency, output int done_pulses,
                          output logic [31:0] result);
        start   = 1'b1;
        op      = op_v;
        data_in = data_v;
        shamt   = shamt_v;
        @(posedge clock); #1;
        start   = 1'b0;
        op      = ~op_v;
        data_in = ~data_v;
        shamt   = ~shamt_v;
        busy_cycles = busy ? 1 : 0;
        latency     = -1;
        done_pulses = 0;
        result      = 32'hDEAD_BEEF;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clock); #1;
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (latency < 0) begin
                    latency = i;
                    result  = data_out;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op = 1'b0;
        data_in = 32'h0;
        shamt = 5'd0;
        #2;
        compared++;
        if (data_out !== 32'h0000_0000) begin
            mismatched++;
            $display("[TB] FAIL reset_data_out: got %h expected %h", data_out, 32'h0);
        end
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_asr_negative();
        int bc, lat, dp;
        logic [31:0] res;
        run_op(1'b1, 32'h8000_0000, 5'd4, bc, lat, dp, res);
        compared++;
        if (bc !== 5) begin
            mismatched++;
            $display("[TB] FAIL asr_busy_cycles: got %0d expected 5", bc);
        end
        compared++;
        if (lat !== 5) begin
            mismatched++;
            $display("[TB] FAIL asr_latency: got %0d expected 5", lat);
        end
        compared++;
        if (dp !== 1) begin
            mismatched++;
            $display("[TB] FAIL asr_done_pulses: got %0d expected 1", dp);
        end
        compared++;
        if (res !== 32'hF800_0000) begin
            mismatched++;
            $display("[TB] FAIL asr_result: got %h expected %h", res, 32'hF800_0000);
        end
    endtask

    task automatic test_shift_vectors();
        logic        ops  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ins  [6] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                  32'h0000_00FF, 32'h8765_4321, 32'h1234_5678};
        logic [4:0]  amts [6] = '{5'd31, 5'd31, 5'd31, 5'd13, 5'd7, 5'd0};
        logic [31:0] exps [6] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                                  32'h001F_E000, 32'hFF0E_CA86, 32'h1234_5678};
        int bc, lat, dp;
        logic [31:0] res;
        for (int v = 0; v < 6; v++) begin
            run_op(ops[v], ins[v], amts[v], bc, lat, dp, res);
            compared++;
            if (res !== exps[v]) begin
                mismatched++;
                $display("[TB] FAIL vector%0d_result: got %h expected %h", v, res, exps[v]);
            end
            compared++;
            if (lat !== 5 || dp !== 1) begin
                mismatched++;
                $display("[TB] FAIL vector%0d_timing: got latency=%0d pulses=%0d expected 5 1", v, lat, dp);
            end
        end
        compared++;
        if (data_out !== 32'h1234_5678 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_hold: got data_out=%h done=%b expected 12345678 0", data_out, done);
        end
    endtask

    task automatic test_start_during_shift();
        int lat, dp;
        logic [31:0] res;
        start   = 1'b1;
        op      = 1'b0;
        data_in = 32'h0000_0003;
        shamt   = 5'd1;
        @(posedge clock); #1;
        start   = 1'b0;
        lat = -1;
        dp  = 0;
        res = 32'hDEAD_BEEF;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clock); #1;
            if (i == 1) begin
                start   = 1'b1;
                op      = 1'b1;
                data_in = 32'hFFFF_FFFF;
                shamt   = 5'd31;
            end
            if (i == 2) start = 1'b0;
            if (i == 3) begin
                compared++;
                if (busy !== 1'b1 || data_out !== 32'h1234_5678) begin
                    mismatched++;
                    $display("[TB] FAIL shift_hold: got busy=%b data_out=%h expected 1 12345678", busy, data_out);
                end
            end
            if (done) begin
                dp++;
                if (lat < 0) begin
                    lat = i;
                    res = data_out;
                end
            end
        end
        compared++;
        if (res !== 32'h0000_0006) begin
            mismatched++;
            $display("[TB] FAIL ignored_start_result: got %h expected %h", res, 32'h6);
        end
        compared++;
        if (lat !== 5 || dp !== 1) begin
            mismatched++;
            $display("[TB] FAIL ignored_start_timing: got latency=%0d pulses=%0d expected 5 1", lat, dp);
        end
    endtask

    task automatic test_back_to_back();
        int bc, lat;
        logic [31:0] res;
        start   = 1'b1;
        op      = 1'b0;
        data_in = 32'h0000_0010;
        shamt   = 5'd2;
        @(posedge clock); #1;
        start   = 1'b0;
        data_in = 32'h0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        start   = 1'b1;
        op      = 1'b1;
        data_in = 32'hF000_0000;
        shamt   = 5'd8;
        @(posedge clock); #1;
        compared++;
        if (done !== 1'b1 || busy !== 1'b0 || data_out !== 32'h0000_0040) begin
            mismatched++;
            $display("[TB] FAIL b2b_first_done: got done=%b busy=%b data_out=%h expected 1 0 00000040", done, busy, data_out);
        end
        @(posedge clock); #1;
        start   = 1'b0;
        data_in = 32'h0;
        bc  = busy ? 1 : 0;
        lat = -1;
        res = 32'hDEAD_BEEF;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clock); #1;
            if (busy) bc++;
            if (done && lat < 0) begin
                lat = i;
                res = data_out;
            end
        end
        compared++;
        if (bc !== 5 || lat !== 5) begin
            mismatched++;
            $display("[TB] FAIL b2b_second_timing: got busy_cycles=%0d latency=%0d expected 5 5", bc, lat);
        end
        compared++;
        if (res !== 32'hFFF0_0000) begin
            mismatched++;
            $display("[TB] FAIL b2b_second_result: got %h expected %h", res, 32'hFFF0_0000);
        end
    endtask

    task automatic test_reset_mid_op();
        int bc, lat, dp;
        logic [31:0] res;
        start   = 1'b1;
        op      = 1'b0;
        data_in = 32'h0000_0001;
        shamt   = 5'd31;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (data_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_reset: got data_out=%h busy=%b done=%b expected 00000000 0 0", data_out, busy, done);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        dp = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (done) dp++;
        end
        compared++;
        if (dp !== 0) begin
            mismatched++;
            $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", dp);
        end
        run_op(1'b1, 32'hFFFF_0000, 5'd16, bc, lat, dp, res);
        compared++;
        if (res !== 32'hFFFF_FFFF || lat !== 5 || dp !== 1) begin
            mismatched++;
            $display("[TB] FAIL after_abort: got result=%h latency=%0d pulses=%0d expected ffffffff 5 1", res, lat, dp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_asr_negative();
        test_shift_vectors();
        test_start_during_shift();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL use a single clock domain; reset SHALL be asynchronous and active-high.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state.
REQ-004 Port: start  input  1  request to begin a shift; sampled on the rising clock edge.
REQ-005 Port: op  input  1  operation select: 0 = logical left shift, 1 = arithmetic right shift.
REQ-006 Port: data_in  input  32  operand; captured when start is accepted.
REQ-007 Port: shamt  input  5  shift amount 0..31; captured when start is accepted.
REQ-008 Port: data_out  output  32  result register.
REQ-009 Port: busy  output  1  high while a shift is in progress.
REQ-010 Port: done  output  1  one-cycle pulse marking that data_out holds a new result.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE.
  - On acceptance: capture data_in, shamt and op into internal registers.
  - Set stage counter to 4 and go to SHIFT.
REQ-013 In SHIFT, each clock edge SHALL process stage k = counter, then decrement the counter.
  - If captured shamt[k] = 1: shift the working register by 2^k (16, 8, 4, 2, 1).
  - If captured shamt[k] = 0: pass the working register unchanged.
REQ-014 Arithmetic right shift SHALL fill vacated upper bits with bit 31 of the working register; left shift SHALL fill vacated lower bits with 0.
REQ-015 The edge that processes stage 0 SHALL move to DONE and load the final value into data_out.
REQ-016 Latency SHALL be fixed and independent of shamt, including shamt = 0.
  - done is high for exactly one cycle.
  - That cycle begins 5 rising edges after the accepting edge.
REQ-017 busy SHALL be high in SHIFT only; busy SHALL be low in IDLE and DONE.
REQ-018 done SHALL be high in DONE only.
REQ-019 From DONE, the FSM SHALL go to SHIFT if start = 1 (back-to-back accept), else to IDLE.
REQ-020 start asserted during SHIFT SHALL be ignored.
  - No capture occurs.
  - No queuing occurs.
  - The in-flight operation is not disturbed.
REQ-021 data_out SHALL hold its last result until the next DONE load.
  - It does not change in IDLE or SHIFT.
  - Input changes after acceptance do not affect the in-flight result.
REQ-022 The stage counter SHALL be 3 bits.
  - It never underflows.
  - The exit from SHIFT is decided on counter = 0.

Reset
REQ-023 On reset assertion, the block SHALL immediately, without waiting for a clock edge:
  - go to IDLE;
  - clear data_out to 32'h0000_0000;
  - clear busy and done to 0;
  - clear the counter and captured operands to 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation.
  - No done pulse is produced for the aborted operation.
  - After reset deasserts, the first start is accepted normally.

Verification
REQ-025 Arithmetic right shift of a negative value: start with op=1, data_in=32'h8000_0000, shamt=4 -> busy high for 5 cycles, then done=1 for one cycle with data_out=32'hF800_0000.
REQ-026 Left shift and sign-boundary cases:
  - op=0, data_in=32'h0000_0001, shamt=31 -> data_out=32'h8000_0000.
  - op=1, data_in=32'h7FFF_FFFF, shamt=31 -> data_out=32'h0000_0000.
  - op=1, data_in=32'hFFFF_FFFF, shamt=31 -> data_out=32'hFFFF_FFFF.
REQ-027 Zero shift: shamt=0, data_in=32'h1234_5678 -> same 5-cycle latency; data_out=32'h1234_5678.
REQ-028 Start during SHIFT: with shamt=1 in flight, pulse start with data_in=32'hFFFF_FFFF -> result is that of the first operation only; exactly one done pulse.
REQ-029 Back-to-back: hold start high through the DONE cycle with a new operand -> second operation is accepted on that edge; its done occurs 5 edges later; busy is low only during the DONE cycle.
REQ-030 Reset mid-operation: assert reset at stage 2 -> data_out=0, busy=0, done=0 at once; no done pulse follows; the next start completes correctly.
